// File: rtl/elevator_call_panel_pkg.sv
// Shared types for the elevator call panel: floor index, FSM states and
// the floor-to-lamp one-hot helper.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 4;

  typedef logic [1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DWELL,
    HALT
  } state_t;

  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input floor_t f);
    logic [NUM_FLOORS-1:0] v;
    v    = '0;
    v[f] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/elevator_call_panel_debounce.sv
// One floor button: 2-flop synchronizer plus debounce counter that emits a
// single registered accept pulse per press.
module call_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_accept
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_accept;

  // Counter parks at DEBOUNCE_CYCLES until the level drops, so a held
  // button produces exactly one accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_cnt    <= '0;
      r_accept <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (!r_sync2) begin
        r_cnt    <= '0;
        r_accept <= 1'b0;
      end else if (r_cnt != CW'(DEBOUNCE_CYCLES)) begin
        r_cnt    <= r_cnt + CW'(1);
        r_accept <= (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
      end else begin
        r_accept <= 1'b0;
      end
    end
  end

  assign o_accept = r_accept;

endmodule

// File: rtl/elevator_call_panel.sv
// Call front-end: latches debounced floor calls, picks the nearest pending
// floor and presents it to the controller until the car has dwelt there.
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SERVICE_CYCLES  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic [1:0]            current_floor,
  input  logic                  motor_stop,
  input  logic                  emergency_stop,
  output logic [NUM_FLOORS-1:0] floor_req,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  served
);

  localparam int unsigned DW = $clog2(SERVICE_CYCLES + 1);

  state_t                r_state;
  floor_t                r_target;
  logic [DW-1:0]         r_dwell;
  logic [NUM_FLOORS-1:0] r_floor_req;
  logic [NUM_FLOORS-1:0] r_pending;
  logic                  r_served;

  logic [NUM_FLOORS-1:0] w_accept;
  logic [NUM_FLOORS-1:0] w_take;
  logic [NUM_FLOORS-1:0] w_clear;
  floor_t                w_sel;
  floor_t                w_best_d;
  floor_t                w_d;
  logic                  w_found;
  logic                  w_at_target;
  logic                  w_serve;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_deb
    call_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (btn[g]),
      .o_accept(w_accept[g])
    );
  end

  // A press for the floor the car is already stopped at is dropped.
  always_comb begin
    w_take = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      w_take[i] = w_accept[i] && !(motor_stop && (current_floor == floor_t'(i)));
    end
  end

  // Nearest pending floor; scanning upward with <= lets ties go higher.
  always_comb begin
    w_sel    = '0;
    w_best_d = '0;
    w_d      = '0;
    w_found  = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      w_d = (floor_t'(i) >= current_floor) ? (floor_t'(i) - current_floor)
                                           : (current_floor - floor_t'(i));
      if (r_pending[i] && (!w_found || (w_d <= w_best_d))) begin
        w_sel    = floor_t'(i);
        w_best_d = w_d;
        w_found  = 1'b1;
      end
    end
  end

  assign w_at_target = motor_stop && (current_floor == r_target);
  assign w_serve     = !emergency_stop && w_at_target &&
                       (((r_state == DWELL) && (r_dwell == DW'(SERVICE_CYCLES - 1))) ||
                        ((r_state == ACTIVE) && (SERVICE_CYCLES == 1)));
  assign w_clear     = w_serve ? floor_onehot(r_target) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending | w_take) & ~w_clear;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_target    <= '0;
      r_dwell     <= '0;
      r_floor_req <= '0;
      r_served    <= 1'b0;
    end else begin
      r_served <= 1'b0;
      if (emergency_stop) begin
        r_state     <= HALT;
        r_floor_req <= '0;
        r_dwell     <= '0;
        r_target    <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (r_pending != '0) begin
              r_target    <= w_sel;
              r_floor_req <= floor_onehot(w_sel);
              r_state     <= ACTIVE;
            end else begin
              r_floor_req <= '0;
            end
          end
          ACTIVE: begin
            if (w_serve) begin
              r_served    <= 1'b1;
              r_floor_req <= '0;
              r_dwell     <= '0;
              r_state     <= IDLE;
            end else if (w_at_target) begin
              r_dwell <= DW'(1);
              r_state <= DWELL;
            end
          end
          DWELL: begin
            if (w_serve) begin
              r_served    <= 1'b1;
              r_floor_req <= '0;
              r_dwell     <= '0;
              r_state     <= IDLE;
            end else if (w_at_target) begin
              r_dwell <= r_dwell + DW'(1);
            end else begin
              r_dwell <= '0;
              r_state <= ACTIVE;
            end
          end
          HALT: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign floor_req = r_floor_req;
  assign pending   = r_pending;
  assign served    = r_served;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed and randomized checks of elevator_call_panel against a
// nearest-floor reference model.
module tb_elevator_call_panel;

  logic       clk;
  logic       reset;
  logic [3:0] btn;
  logic [1:0] current_floor;
  logic       motor_stop;
  logic       emergency_stop;
  logic [3:0] floor_req;
  logic [3:0] pending;
  logic       served;

  int n_cmp;
  int n_bad;

  elevator_call_panel #(
    .DEBOUNCE_CYCLES(4),
    .SERVICE_CYCLES (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn           (btn),
    .current_floor (current_floor),
    .motor_stop    (motor_stop),
    .emergency_stop(emergency_stop),
    .floor_req     (floor_req),
    .pending       (pending),
    .served        (served)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: nearest pending floor by absolute distance, ties to the higher floor.
  function automatic int nearest(input logic [3:0] m, input int cf);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = 100;
    for (int f = 0; f < 4; f++) begin
      if (m[f]) begin
        d = (f > cf) ? (f - cf) : (cf - f);
        if (d < bestd || (d == bestd && f > best)) begin
          bestd = d;
          best  = f;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [3:0] oh(input int f);
    logic [3:0] v;
    v    = '0;
    v[f] = 1'b1;
    return v;
  endfunction

  task automatic pulse_reset();
    btn   = '0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  logic [3:0] m;
  logic [3:0] gl;
  logic [3:0] pend;
  int         g;
  int         cfv;
  int         t;

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    reset          = 1'b0;
    btn            = '0;
    current_floor  = 2'd0;
    motor_stop     = 1'b0;
    emergency_stop = 1'b0;
    repeat (2) tick();
    chk("reset_req", 32'(floor_req), 32'h0);
    chk("reset_pend", 32'(pending), 32'h0);
    chk("reset_served", 32'(served), 32'h0);
    reset = 1'b1;
    repeat (2) tick();

    // Idle press on floor 3, latency 7 to pending, +1 to floor_req
    current_floor = 2'd0;
    motor_stop    = 1'b1;
    btn           = 4'b1000;
    repeat (6) tick();
    chk("press_early", 32'(pending), 32'h0);
    tick();
    chk("press_pend", 32'(pending), 32'h8);
    chk("press_req_lag", 32'(floor_req), 32'h0);
    tick();
    chk("press_req", 32'(floor_req), 32'h8);
    repeat (2) tick();
    chk("press_req_hold", 32'(floor_req), 32'h8);

    // Service at floor 3
    btn           = '0;
    current_floor = 2'd3;
    tick();
    chk("svc_d1", 32'(served), 32'h0);
    tick();
    chk("svc_d2", 32'(served), 32'h0);
    tick();
    chk("svc_served", 32'(served), 32'h1);
    chk("svc_pend", 32'(pending), 32'h0);
    chk("svc_req", 32'(floor_req), 32'h0);
    tick();
    chk("svc_pulse_end", 32'(served), 32'h0);
    chk("svc_idle_req", 32'(floor_req), 32'h0);

    // Glitch rejection
    current_floor = 2'd0;
    motor_stop    = 1'b0;
    btn           = 4'b0100;
    repeat (3) tick();
    btn = '0;
    repeat (8) tick();
    chk("glitch_pend", 32'(pending), 32'h0);
    chk("glitch_req", 32'(floor_req), 32'h0);

    // Nearest: floors 0 and 3 from floor 1
    current_floor = 2'd1;
    btn           = 4'b1001;
    repeat (7) tick();
    chk("near_pend", 32'(pending), 32'h9);
    tick();
    chk("near_req", 32'(floor_req), 32'h1);
    pulse_reset();

    // Tie: floors 0 and 2 from floor 1 -> higher
    current_floor = 2'd1;
    btn           = 4'b0101;
    repeat (7) tick();
    chk("tie_pend", 32'(pending), 32'h5);
    tick();
    chk("tie_req", 32'(floor_req), 32'h4);
    pulse_reset();

    // Emergency with a press latched during HALT
    current_floor = 2'd3;
    btn           = 4'b0100;
    repeat (8) tick();
    chk("emg_pre_req", 32'(floor_req), 32'h4);
    btn = 4'b0001;
    repeat (5) tick();
    emergency_stop = 1'b1;
    tick();
    chk("emg_req", 32'(floor_req), 32'h0);
    chk("emg_pend", 32'(pending), 32'h4);
    chk("emg_served", 32'(served), 32'h0);
    tick();
    chk("emg_latch", 32'(pending), 32'h5);
    chk("emg_req2", 32'(floor_req), 32'h0);
    emergency_stop = 1'b0;
    btn            = '0;
    tick();
    chk("emg_rel_req", 32'(floor_req), 32'h0);
    tick();
    chk("emg_reselect", 32'(floor_req), 32'h4);

    // Dwell abort then full service
    current_floor = 2'd2;
    motor_stop    = 1'b1;
    repeat (2) tick();
    motor_stop = 1'b0;
    tick();
    chk("abort_served", 32'(served), 32'h0);
    chk("abort_req", 32'(floor_req), 32'h4);
    motor_stop = 1'b1;
    repeat (2) tick();
    chk("abort_restart", 32'(served), 32'h0);
    tick();
    chk("abort_svc", 32'(served), 32'h1);
    chk("abort_pend", 32'(pending), 32'h1);
    tick();
    chk("abort_next", 32'(floor_req), 32'h1);

    // Asynchronous reset mid-DWELL
    current_floor = 2'd0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("arst_req", 32'(floor_req), 32'h0);
    chk("arst_pend", 32'(pending), 32'h0);
    chk("arst_served", 32'(served), 32'h0);
    tick();
    reset = 1'b1;
    tick();

    // Press for the floor the car is stopped at is ignored
    current_floor = 2'd1;
    motor_stop    = 1'b1;
    btn           = 4'b0010;
    repeat (9) tick();
    chk("ign_pend", 32'(pending), 32'h0);
    chk("ign_req", 32'(floor_req), 32'h0);
    btn = '0;

    // Randomized call sets with glitches on unpressed floors
    for (int it = 0; it < 20; it++) begin
      btn            = '0;
      motor_stop     = 1'b0;
      emergency_stop = 1'b0;
      repeat (3) tick();
      cfv           = int'($urandom_range(0, 3));
      current_floor = 2'(cfv);
      m             = 4'($urandom_range(1, 15));
      gl            = 4'($urandom) & ~m;
      g             = int'($urandom_range(1, 3));
      btn           = m | gl;
      repeat (g) tick();
      btn = m;
      repeat (7 - g) tick();
      chk("rnd_pend", 32'(pending), 32'(m));
      btn = '0;
      tick();
      pend = m;
      while (pend != '0) begin
        t = nearest(pend, cfv);
        chk("rnd_req", 32'(floor_req), 32'(oh(t)));
        cfv           = t;
        current_floor = 2'(t);
        motor_stop    = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 2)) tick();
          motor_stop = 1'b0;
          tick();
          chk("rnd_abort", 32'(served), 32'h0);
          motor_stop = 1'b1;
        end
        repeat (2) tick();
        chk("rnd_early", 32'(served), 32'h0);
        tick();
        chk("rnd_served", 32'(served), 32'h1);
        pend[t] = 1'b0;
        chk("rnd_clear", 32'(pending), 32'(pend));
        chk("rnd_gap", 32'(floor_req), 32'h0);
        tick();
      end
      chk("rnd_done", 32'(floor_req), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/elevator_call_panel.md
Name: elevator_call_panel

Overview:
- Hall/car call front-end that produces the floor_req input of the elevator controller.
- Debounces and latches raw floor buttons, then presents one registered one-hot target on floor_req.
- Watches current_floor, motor_stop and emergency_stop to decide when a call is served, then clears it and selects the next target.
- Owns the pending-call lamps.

Parameters:
- NUM_FLOORS, 4, number of floors; only 4 is supported (2-bit floor index).
- DEBOUNCE_CYCLES, 4, consecutive synchronized-high cycles needed to accept a press.
- SERVICE_CYCLES, 3, consecutive cycles the car must sit stopped at the target floor before the call counts as served.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, asynchronous active-low reset.
- btn, input, 4, raw asynchronous floor buttons; bit i = floor i.
- current_floor, input, 2, car floor index from the controller.
- motor_stop, input, 1, controller reports car stopped.
- emergency_stop, input, 1, emergency halt request.
- floor_req, output, 4, registered one-hot target floor to the controller; 0 = no request.
- pending, output, 4, latched outstanding calls (lamp drive).
- served, output, 1, one-cycle pulse when a call is cleared.

Behaviour:
- Reset (reset=0): floor_req=0, pending=0, served=0, FSM=IDLE, all synchronizer flops, debounce and dwell counters = 0. Takes effect immediately. Reset mid-operation discards all calls.
- Input path per button:
  - 2-flop synchronizer, then debounce counter.
  - Press accepted on the cycle the synchronized level has been high DEBOUNCE_CYCLES consecutive cycles.
  - Exactly one acceptance per press; the level must return low before re-arming.
  - A low cycle before the count completes resets the counter (glitch rejected).
  - Accepted press sets pending[i] on the next edge. Latency from btn rise to pending: 2+DEBOUNCE_CYCLES+1 = 7 cycles at default.
- Press ignored (pending not set) if, in the accept cycle, motor_stop=1 and current_floor==i.
- Press for an already-pending floor: no effect.
- Press accepted in the same cycle its floor is cleared: the clear wins.
- FSM states: IDLE, ACTIVE, DWELL, HALT.
  - IDLE:
    - floor_req=0.
    - If emergency_stop=1, go to HALT.
    - Else if pending!=0, latch target = selection result and go to ACTIVE; floor_req becomes one-hot(target) on that edge.
  - ACTIVE:
    - floor_req=one-hot(target), held stable even if nearer calls arrive.
    - If motor_stop=1 and current_floor==target, go to DWELL with dwell count=1.
  - DWELL:
    - Count increments each cycle while motor_stop=1 and current_floor==target; any violation returns to ACTIVE with count 0.
    - When the count reaches SERVICE_CYCLES: clear pending[target], pulse served, floor_req=0, go to IDLE.
    - Next target is selected no earlier than the following cycle, so floor_req is 0 for at least one cycle between targets.
  - HALT:
    - Entered from any state when emergency_stop=1; this has priority over all other transitions.
    - floor_req=0 on the next edge, dwell count cleared, target forgotten, pending retained.
    - New presses are still latched.
    - On emergency_stop=0, go to IDLE and reselect.
- Selection (combinational over pending and current_floor):
  - Choose the pending floor minimising |f-current_floor| (2-bit unsigned difference).
  - Tie goes to the higher floor.
  - Result is valid only when pending!=0.
- served is high for exactly one cycle per cleared call. It is never asserted in HALT or IDLE.

Decomposition:
- Package elevator_pkg holds:
  - NUM_FLOORS;
  - floor index typedef (2-bit);
  - FSM state enum {IDLE, ACTIVE, DWELL, HALT};
  - a function returning the one-hot encoding of a floor index.
- Sub-module call_debounce (synchronizer plus counter, one-cycle accept pulse out) is instantiated 4 times.
- Selection, latches and FSM live in the top module.

Test Plan:
- Idle press: current_floor=0, motor_stop=1, btn=4'b1000 held 10 cycles -> pending=4'b1000 7 cycles after btn rise; floor_req=4'b1000 one cycle later.
- Service: continue the previous scenario; drive current_floor=3, motor_stop=1 for 3 cycles -> served pulses once, pending=0, floor_req=0 on the same edge, FSM=IDLE.
- Glitch reject: btn[2] high for 3 cycles then low -> pending stays 0.
- Nearest and tie:
  - current_floor=1, pending from presses on floors 0 and 3 -> floor_req=4'b0001.
  - Separately, current_floor=1 with presses on floors 0 and 2 -> floor_req=4'b0100 (tie goes higher).
- Emergency: floor_req=4'b0100 in ACTIVE, emergency_stop=1 for 2 cycles -> floor_req=0 next edge, pending=4'b0100 retained, a btn[0] press during HALT is latched; after release floor_req=4'b0100 is re-presented within 2 cycles.
- Dwell abort and reset:
  - motor_stop drops after 2 DWELL cycles -> returns to ACTIVE, no served pulse.
  - reset=0 mid-DWELL -> all outputs 0 immediately.
